jtag_uart_tx_arbiter: RTL
=========================

// Module: jtag_uart_tx_arbiter
// PURPOSE
//   Shares the CPU->JTAG write side of the JTAG UART bridge between NUM_REQ byte-stream
//   requesters (CPU console, debug monitor, trace dumper, ...). Round-robin arbitration at
//   packet granularity: a granted requester keeps the UART until it sends a byte flagged
//   last, so messages never interleave. An idle-timeout reclaims the UART from a stalled owner.
// PARAMETERS
//   NUM_REQ   4    number of requesters, 2..8
//   TIMEOUT   255  owner-idle cycles tolerated before forced release, 1..2^TO_W-1
//   TO_W      8    width of the idle-timeout counter
//   ID_W      2    width of grant_id, = clog2(NUM_REQ)
// PORTS
//   clk          in   1          system clock
//   rst          in   1          asynchronous reset, active high
//   req_valid    in   NUM_REQ    requester i presents a byte
//   req_data     in   8*NUM_REQ  byte of requester i at [8*i+7:8*i]
//   req_last     in   NUM_REQ    byte of requester i ends its packet
//   req_ready    out  NUM_REQ    byte of requester i accepted this cycle when valid&ready
//   uart_data    out  8          to UART write-FIFO data input
//   uart_we      out  1          to UART write-FIFO write enable
//   uart_full    in   1          UART write FIFO full
//   grant_id     out  ID_W       current/last owner index
//   busy         out  1          1 while in HOLD
//   timeout_evt  out  1          one-cycle pulse on forced release
// BEHAVIOUR
//   Reset: state=IDLE, last_grant=NUM_REQ-1 (so requester 0 has first priority),
//     grant_id=0, idle_cnt=0, busy=0, timeout_evt=0, req_ready=0, uart_we=0, uart_data=0.
//   States: IDLE, HOLD (registered).
//   IDLE: if any req_valid, pick first set bit scanning last_grant+1, +2, ... modulo NUM_REQ;
//     register grant_id, clear idle_cnt, go HOLD. No byte transferred in IDLE; one cycle
//     arbitration latency from req_valid to first possible transfer.
//   HOLD (owner g = grant_id):
//     req_ready[g] = ~uart_full (combinational); req_ready[i!=g] = 0.
//     xfer = req_valid[g] & ~uart_full; uart_we = xfer; uart_data = req_data[g] else 0.
//     Combinational write path to the FIFO; uart_we never asserted while uart_full=1.
//     xfer & req_last[g]: last_grant<=g, go IDLE (next packet arbitrated next cycle).
//     idle_cnt: cleared on xfer; held while uart_full=1 (backpressure is not owner idleness);
//       else incremented while req_valid[g]=0.
//     idle_cnt == TIMEOUT-1 and incrementing: go IDLE, last_grant<=g, timeout_evt=1 next cycle.
//     Timeout and xfer never coincide (xfer clears counter).
//   Non-owner requests in HOLD are held pending; requesters must keep valid/data stable until
//     ready. req_last on a non-owner has no effect.
//   busy = (state==HOLD). grant_id retains the last owner in IDLE.
//   Reset mid-packet: everything returns to reset values immediately; a partial packet may
//     already sit in the UART FIFO (no rollback).
//   Byte-width only; no internal buffering; throughput 1 byte/cycle within a packet.
// TESTING
//   Req1 sends 0x41,0x42,0x43(last), uart_full=0 -> grant_id=1 after 1 cycle, uart_we 3
//     consecutive cycles with 0x41,0x42,0x43, busy falls after 0x43.
//   Req0 and req2 both valid from reset, 2-byte packets -> req0 packet fully on uart_data
//     before any req2 byte; then req2; next contest 0 vs 2 goes to 0 again (after 2).
//   Req0 and req1 continuously requesting single-byte packets -> grants alternate 0,1,0,1.
//   uart_full=1 for 10 cycles mid-packet -> uart_we=0, req_ready=0, no timeout, resumes
//     with next byte in order when full drops.
//   TIMEOUT=4: req3 sends 1 byte (not last) then drops valid -> release after 4 idle
//     cycles, timeout_evt 1-cycle pulse, pending req0 granted next.
//   rst asserted during req2 packet byte 2 of 4 -> outputs zero same cycle; after release
//     req0 wins first.

Source files
------------

// File: rtl/jtag_uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : jtag_uart_tx_arbiter_if
// Description : Requester-side and UART write-side bundle of the JTAG UART
//               TX arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface jtag_uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           uart_data;
    logic                 uart_we;
    logic                 uart_full;
    logic [ID_W-1:0]      grant_id;
    logic                 busy;
    logic                 timeout_evt;

    // master: requesters plus the UART FIFO status; slave: the arbiter
    modport master (
        output req_valid, req_data, req_last, uart_full,
        input  req_ready, uart_data, uart_we, grant_id, busy, timeout_evt
    );

    modport slave (
        input  req_valid, req_data, req_last, uart_full,
        output req_ready, uart_data, uart_we, grant_id, busy, timeout_evt
    );
endinterface
`default_nettype wire

// File: rtl/jtag_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : jtag_uart_tx_arbiter
// Description : Packet-granular round-robin arbiter sharing the JTAG UART
//               write FIFO, with idle-timeout release of a stalled owner.
// Revision    : 1.0 - initial release
// ============================================================================
module jtag_uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8,
    parameter int ID_W    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    jtag_uart_tx_arbiter_if.slave  bus
);

    localparam logic [0:0]      c_IDLE      = 1'b0;
    localparam logic [0:0]      c_HOLD      = 1'b1;
    localparam logic [TO_W-1:0] c_TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] c_LAST_INIT = ID_W'(NUM_REQ - 1);

    logic [0:0]      r_state;
    logic [ID_W-1:0] r_grant_id;
    logic [ID_W-1:0] r_last_grant;
    logic [TO_W-1:0] r_idle_cnt;
    logic            r_timeout_evt;

    logic            w_hold;
    logic            w_owner_valid;
    logic            w_owner_last;
    logic [7:0]      w_owner_data;
    logic            w_xfer;
    logic            w_found;
    logic [ID_W-1:0] w_pick;
    int              w_idx;

    assign w_hold = (r_state == c_HOLD);
    assign w_xfer = w_hold & w_owner_valid & ~bus.uart_full;

    always_comb begin
        w_owner_valid = 1'b0;
        w_owner_last  = 1'b0;
        w_owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == ID_W'(i)) begin
                w_owner_valid = bus.req_valid[i];
                w_owner_last  = bus.req_last[i];
                w_owner_data  = bus.req_data[8*i +: 8];
            end
        end
    end

    // Scan starts just after the previous owner so every requester gets a turn
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last_grant;
        w_idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_idx = (int'(r_last_grant) + k) % NUM_REQ;
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_pick  = ID_W'(w_idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_grant_id    <= '0;
            r_last_grant  <= c_LAST_INIT;
            r_idle_cnt    <= '0;
            r_timeout_evt <= 1'b0;
        end else begin
            r_timeout_evt <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_found) begin
                        r_grant_id <= w_pick;
                        r_idle_cnt <= '0;
                        r_state    <= c_HOLD;
                    end
                end
                c_HOLD: begin
                    if (w_xfer) begin
                        r_idle_cnt <= '0;
                        if (w_owner_last) begin
                            r_last_grant <= r_grant_id;
                            r_state      <= c_IDLE;
                        end
                    end else if (!bus.uart_full && !w_owner_valid) begin
                        // A full FIFO is not the owner's fault, so only real idleness counts
                        if (r_idle_cnt == c_TO_LAST) begin
                            r_last_grant  <= r_grant_id;
                            r_state       <= c_IDLE;
                            r_idle_cnt    <= '0;
                            r_timeout_evt <= 1'b1;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + TO_W'(1);
                        end
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = w_hold & ~bus.uart_full & (r_grant_id == ID_W'(gi));
        end
    endgenerate

    assign bus.uart_we     = w_xfer;
    assign bus.uart_data   = w_xfer ? w_owner_data : 8'h00;
    assign bus.grant_id    = r_grant_id;
    assign bus.busy        = w_hold;
    assign bus.timeout_evt = r_timeout_evt;

endmodule
`default_nettype wire
